// File: rtl/bullet_ctrl.sv
// bullet_ctrl: single-bullet spawn/flight/explosion controller for one tank sprite.
// Define BULLET_EXPLOSION_ANIM_EN to build the timed EXPLODE state and the explode_o box.
module bullet_ctrl #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int TANK_SIZE     = 32,
    parameter int BULLET_SIZE   = 4,
    parameter int STEP          = 2,
    parameter int EXPLODE_TICKS = 8
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       tick_i,
    input  logic       fire_i,
    input  logic [1:0] dir_i,
    input  logic [9:0] tank_x_i,
    input  logic [9:0] tank_y_i,
    input  logic       tank_alive_i,
    input  logic       explose_i,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    output logic       bullet_o,
    output logic       explode_o,
    output logic       busy_o,
    output logic [9:0] bullet_x_o,
    output logic [9:0] bullet_y_o
);
    localparam logic [10:0] C  = 11'((TANK_SIZE - BULLET_SIZE) / 2);
    localparam logic [10:0] TS = 11'(TANK_SIZE);
    localparam logic [10:0] BS = 11'(BULLET_SIZE);
    localparam logic [10:0] ST = 11'(STEP);
    localparam logic [10:0] SW = 11'(SCREEN_W);
    localparam logic [10:0] SH = 11'(SCREEN_H);

    typedef enum logic [1:0] {IDLE = 2'd0, FLYING = 2'd1, EXPLODE = 2'd2} state_t;

`ifdef BULLET_EXPLOSION_ANIM_EN
    localparam state_t HIT_STATE = EXPLODE;
`else
    localparam state_t HIT_STATE = IDLE;
`endif

    state_t      state;
    logic [1:0]  dir_q;
    logic [9:0]  pos_x, pos_y;
    logic [10:0] tx, ty, px, py, pix_x, pix_y;

    // tick_i and fire_i are sampled on the clock edge only; neither needs an acknowledge.
    assign tx    = {1'b0, tank_x_i};
    assign ty    = {1'b0, tank_y_i};
    assign px    = {1'b0, pos_x};
    assign py    = {1'b0, pos_y};
    assign pix_x = {1'b0, pix_x_i};
    assign pix_y = {1'b0, pix_y_i};

    logic [10:0] spawn_x, spawn_y;
    logic        spawn_under, spawn_ok;

    always_comb begin
        spawn_x     = tx + C;
        spawn_y     = ty - BS;
        spawn_under = (ty < BS);
        case (dir_i)
            2'b01: begin
                spawn_x     = tx + TS;
                spawn_y     = ty + C;
                spawn_under = 1'b0;
            end
            2'b10: begin
                spawn_x     = tx + C;
                spawn_y     = ty + TS;
                spawn_under = 1'b0;
            end
            2'b11: begin
                spawn_x     = tx - BS;
                spawn_y     = ty + C;
                spawn_under = (tx < BS);
            end
            default: ;
        endcase
    end

    // An underflowed spawn wraps to a huge value, so the underflow flag gates it.
    assign spawn_ok = !spawn_under && (spawn_x + BS <= SW) && (spawn_y + BS <= SH);

    logic [9:0] next_x, next_y;
    logic       at_edge;

    always_comb begin
        next_x  = pos_x;
        next_y  = pos_y;
        at_edge = 1'b0;
        case (dir_q)
            2'b00: begin
                next_y  = pos_y - 10'(STEP);
                at_edge = (py < ST);
            end
            2'b01: begin
                next_x  = pos_x + 10'(STEP);
                at_edge = (px + BS + ST > SW);
            end
            2'b10: begin
                next_y  = pos_y + 10'(STEP);
                at_edge = (py + BS + ST > SH);
            end
            default: begin
                next_x  = pos_x - 10'(STEP);
                at_edge = (px < ST);
            end
        endcase
    end

`ifdef BULLET_EXPLOSION_ANIM_EN
    localparam int CW = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;
    logic [CW-1:0] cnt;

    // Held at zero outside EXPLODE, so it is already clear on entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)              cnt <= '0;
        else if (state != EXPLODE)  cnt <= '0;
        else if (tick_i)            cnt <= cnt + CW'(1);
    end
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            dir_q <= 2'b00;
            pos_x <= '0;
            pos_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire_i && tank_alive_i && spawn_ok) begin
                        dir_q <= dir_i;
                        pos_x <= spawn_x[9:0];
                        pos_y <= spawn_y[9:0];
                        state <= FLYING;
                    end
                end
                FLYING: begin
                    if (explose_i) begin
                        state <= HIT_STATE;
                    end else if (tick_i) begin
                        if (at_edge) begin
                            state <= HIT_STATE;
                        end else begin
                            pos_x <= next_x;
                            pos_y <= next_y;
                        end
                    end
                end
`ifdef BULLET_EXPLOSION_ANIM_EN
                EXPLODE: begin
                    if (tick_i && cnt == CW'(EXPLODE_TICKS - 1)) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o     = (state != IDLE);
    assign bullet_x_o = pos_x;
    assign bullet_y_o = pos_y;

    assign bullet_o = (state == FLYING)
                    && (pix_x >= px) && (pix_x < px + BS)
                    && (pix_y >= py) && (pix_y < py + BS);

`ifdef BULLET_EXPLOSION_ANIM_EN
    // 4*BS square centred on the bullet box; the low edge clamps at 0 instead of wrapping.
    localparam logic [10:0] LO_OFF = 11'(2 * BULLET_SIZE - BULLET_SIZE / 2);
    localparam logic [10:0] HI_OFF = 11'(2 * BULLET_SIZE + BULLET_SIZE / 2);
    logic [10:0] ex_lo_x, ex_lo_y;

    assign ex_lo_x = (px >= LO_OFF) ? px - LO_OFF : 11'd0;
    assign ex_lo_y = (py >= LO_OFF) ? py - LO_OFF : 11'd0;

    assign explode_o = (state == EXPLODE)
                     && (pix_x >= ex_lo_x) && (pix_x < px + HI_OFF)
                     && (pix_y >= ex_lo_y) && (pix_y < py + HI_OFF);
`else
    assign explode_o = 1'b0;
`endif

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl: stimulus pushes each expected output change into a
// queue; a negedge monitor pops one entry whenever the observed output word changes.
module tb_bullet_ctrl;
    localparam int EXPLODE_TICKS = 8;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b1;
    logic       tick_i = 1'b0;
    logic       fire_i = 1'b0;
    logic [1:0] dir_i = 2'b00;
    logic [9:0] tank_x_i = 10'd0;
    logic [9:0] tank_y_i = 10'd0;
    logic       tank_alive_i = 1'b1;
    logic       explose_i = 1'b0;
    logic [9:0] pix_x_i = 10'd1000;
    logic [9:0] pix_y_i = 10'd1000;
    logic       bullet_o, explode_o, busy_o;
    logic [9:0] bullet_x_o, bullet_y_o;

    int checks = 0;
    int errors = 0;
    logic [22:0] exp_q[$];
    bit mon_en = 1'b0;

    bullet_ctrl dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .tick_i       (tick_i),
        .fire_i       (fire_i),
        .dir_i        (dir_i),
        .tank_x_i     (tank_x_i),
        .tank_y_i     (tank_y_i),
        .tank_alive_i (tank_alive_i),
        .explose_i    (explose_i),
        .pix_x_i      (pix_x_i),
        .pix_y_i      (pix_y_i),
        .bullet_o     (bullet_o),
        .explode_o    (explode_o),
        .busy_o       (busy_o),
        .bullet_x_o   (bullet_x_o),
        .bullet_y_o   (bullet_y_o)
    );

    always #5 clk_i = ~clk_i;

    // Observation word: {busy, bullet, explode, x, y}.
    function automatic logic [22:0] mk(input logic b, input logic bo, input logic eo,
                                       input int x, input int y);
        return {b, bo, eo, 10'(x), 10'(y)};
    endfunction

    function automatic logic [22:0] cur_obs();
        return {busy_o, bullet_o, explode_o, bullet_x_o, bullet_y_o};
    endfunction

    always @(negedge clk_i) begin : monitor
        logic [22:0] o, e, last_obs;
        o = cur_obs();
        if (mon_en && o !== last_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change got %h required no change from %h", o, last_obs);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL transition got %h required %h", o, e);
                end
            end
        end
        last_obs = o;
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fire(input int x, input int y, input logic [1:0] d,
                        input bit push, input logic [22:0] e);
        cyc();
        tank_x_i = 10'(x);
        tank_y_i = 10'(y);
        dir_i    = d;
        fire_i   = 1'b1;
        if (push) exp_q.push_back(e);
        cyc();
        fire_i = 1'b0;
    endtask

    task automatic tick_exp(input logic [22:0] e);
        cyc();
        tick_i = 1'b1;
        exp_q.push_back(e);
        cyc();
        tick_i = 1'b0;
    endtask

    task automatic tick_quiet();
        cyc();
        tick_i = 1'b1;
        cyc();
        tick_i = 1'b0;
    endtask

    task automatic set_pix(input int x, input int y, input bit push, input logic [22:0] e);
        cyc();
        pix_x_i = 10'(x);
        pix_y_i = 10'(y);
        if (push) exp_q.push_back(e);
    endtask

    // Edge-triggered explosion; pixel must already sit in the explosion box.
    task automatic edge_tick(input int x, input int y);
`ifdef BULLET_EXPLOSION_ANIM_EN
        tick_exp(mk(1, 0, 1, x, y));
        repeat (EXPLODE_TICKS - 1) tick_quiet();
        tick_exp(mk(0, 0, 0, x, y));
`else
        tick_exp(mk(0, 0, 0, x, y));
`endif
    endtask

    // Leaves reset asserted; outputs must clear with no clock edge.
    task automatic reset_assert();
        cyc();
        exp_q.push_back(23'd0);
        reset_ni = 1'b0;
        #1;
        checks++;
        if (cur_obs() !== 23'd0) begin
            errors++;
            $display("FAIL async_reset got %h required 0", cur_obs());
        end
        repeat (2) cyc();
    endtask

    initial begin
        #2 reset_ni = 1'b0;
        repeat (2) cyc();
        checks++;
        if (cur_obs() !== 23'd0) begin
            errors++;
            $display("FAIL reset_state got %h required 0", cur_obs());
        end
        reset_ni = 1'b1;
        mon_en   = 1'b1;

        // Fire up from (100,200), three ticks up.
        fire(100, 200, 2'b00, 1, mk(1, 0, 0, 114, 196));
        tick_exp(mk(1, 0, 0, 114, 194));
        tick_exp(mk(1, 0, 0, 114, 192));
        tick_exp(mk(1, 0, 0, 114, 190));

        // Render box edges at (114,190).
        set_pix(117, 193, 1, mk(1, 1, 0, 114, 190));
        set_pix(118, 193, 1, mk(1, 0, 0, 114, 190));
        set_pix(114, 190, 1, mk(1, 1, 0, 114, 190));
        set_pix(114, 189, 1, mk(1, 0, 0, 114, 190));
        set_pix(1000, 1000, 0, 23'd0);

        // Fire and dir ignored in flight; tank death does not stop the bullet.
        fire(0, 0, 2'b01, 0, 23'd0);
        tank_alive_i = 1'b0;
        tick_exp(mk(1, 0, 0, 114, 188));

        // Hit with a simultaneous tick: position held.
        set_pix(110, 184, 0, 23'd0);
        cyc();
        explose_i = 1'b1;
        tick_i    = 1'b1;
`ifdef BULLET_EXPLOSION_ANIM_EN
        exp_q.push_back(mk(1, 0, 1, 114, 188));
`else
        exp_q.push_back(mk(0, 0, 0, 114, 188));
`endif
        cyc();
        explose_i = 1'b0;
        tick_i    = 1'b0;
        tank_alive_i = 1'b1;

`ifdef BULLET_EXPLOSION_ANIM_EN
        set_pix(107, 184, 1, mk(1, 0, 0, 114, 188));
        set_pix(108, 197, 1, mk(1, 0, 1, 114, 188));
        set_pix(108, 198, 1, mk(1, 0, 0, 114, 188));
        set_pix(115, 189, 1, mk(1, 0, 1, 114, 188));
        set_pix(1000, 1000, 1, mk(1, 0, 0, 114, 188));
        fire(100, 200, 2'b00, 0, 23'd0);
        cyc();
        explose_i = 1'b1;
        cyc();
        explose_i = 1'b0;
        repeat (EXPLODE_TICKS - 1) tick_quiet();
        tick_exp(mk(0, 0, 0, 114, 188));
`else
        set_pix(1000, 1000, 0, 23'd0);
`endif

        // Hit in IDLE ignored; dead tank may not fire.
        cyc();
        explose_i = 1'b1;
        cyc();
        explose_i = 1'b0;
        tank_alive_i = 1'b0;
        fire(100, 200, 2'b00, 0, 23'd0);
        tank_alive_i = 1'b1;

        // Off-screen spawns are dropped.
        fire(300, 2, 2'b00, 0, 23'd0);
        fire(2, 100, 2'b11, 0, 23'd0);
        fire(200, 448, 2'b10, 0, 23'd0);
        fire(606, 100, 2'b01, 0, 23'd0);

        // Right edge: x=634 may still step to 636, then explodes there.
        fire(602, 100, 2'b01, 1, mk(1, 0, 0, 634, 114));
        tick_exp(mk(1, 0, 0, 636, 114));
        set_pix(632, 110, 0, 23'd0);
        edge_tick(636, 114);
        set_pix(1000, 1000, 0, 23'd0);

        // Bottom edge from the last legal spawn row.
        fire(200, 444, 2'b10, 1, mk(1, 0, 0, 214, 476));
        set_pix(208, 470, 0, 23'd0);
        edge_tick(214, 476);
        set_pix(1000, 1000, 0, 23'd0);

        // Left edge down to x=0; explosion box clamps at 0.
        fire(40, 300, 2'b11, 1, mk(1, 0, 0, 36, 314));
        for (int i = 1; i <= 18; i++) tick_exp(mk(1, 0, 0, 36 - 2 * i, 314));
        set_pix(0, 310, 0, 23'd0);
`ifdef BULLET_EXPLOSION_ANIM_EN
        tick_exp(mk(1, 0, 1, 0, 314));
        reset_assert();
        cyc();
        reset_ni = 1'b1;
`else
        tick_exp(mk(0, 0, 0, 0, 314));
`endif

        // Reset mid-flight, then fire on the first edge after release.
        fire(100, 200, 2'b00, 1, mk(1, 0, 0, 114, 196));
        set_pix(115, 197, 1, mk(1, 1, 0, 114, 196));
        reset_assert();
        cyc();
        reset_ni = 1'b1;
        tank_x_i = 10'd100;
        tank_y_i = 10'd200;
        dir_i    = 2'b00;
        fire_i   = 1'b1;
        exp_q.push_back(mk(1, 1, 0, 114, 196));
        cyc();
        fire_i = 1'b0;

        repeat (5) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
